// File: rtl/kf8259_priority_controller.sv
// KF8259 priority controller: IRR/ISR/priority pointer with registered
// fully nested or rotating resolution and acknowledge/EOI handshakes.
module kf8259_priority_controller #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] interrupt_request,
    input  logic [N_IRQ-1:0] interrupt_mask,
    input  logic             auto_rotate,
    input  logic             auto_eoi,
    input  logic             int_ack,
    input  logic             eoi_nonspecific,
    input  logic             eoi_specific,
    input  logic [ID_W-1:0]  eoi_level,
    input  logic             set_priority,
    output logic             int_out,
    output logic [ID_W-1:0]  ack_id,
    output logic             ack_spurious,
    output logic [N_IRQ-1:0] in_service_register,
    output logic [N_IRQ-1:0] interrupt
);

    logic [N_IRQ-1:0] irr;
    logic [N_IRQ-1:0] isr;
    logic [N_IRQ-1:0] masked;
    logic [N_IRQ-1:0] win_vec;
    logic [N_IRQ-1:0] isr_set;
    logic [N_IRQ-1:0] isr_clr;
    logic [ID_W-1:0]  lowest_ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  req_id;
    logic [ID_W-1:0]  isr_id;
    logic [ID_W-1:0]  cur_id;
    logic             req_found;
    logic             isr_found;
    logic             win;
    logic             lvl_ok;
    logic             granted;
    int               req_rank;
    int               isr_rank;

    assign masked              = irr & ~interrupt_mask;
    assign in_service_register = isr;
    assign granted             = int_ack & int_out;
    assign lvl_ok              = int'(eoi_level) < N_IRQ;

    // Walk levels from highest priority (rank 0) down to lowest_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        req_found = 1'b0;
        isr_found = 1'b0;
        req_id    = '0;
        isr_id    = '0;
        req_rank  = 0;
        isr_rank  = 0;
        for (int k = 0; k < N_IRQ; k++) begin
            idx = (int'(lowest_ptr) + 1 + k) % N_IRQ;
            if (!req_found && masked[idx]) begin
                req_found = 1'b1;
                req_id    = ID_W'(idx);
                req_rank  = k;
            end
            if (!isr_found && isr[idx]) begin
                isr_found = 1'b1;
                isr_id    = ID_W'(idx);
                isr_rank  = k;
            end
        end
    end

    assign win = req_found && (!isr_found || req_rank < isr_rank);

    always_comb begin
        win_vec = '0;
        if (win) win_vec[req_id] = 1'b1;
    end

    always_comb begin
        cur_id = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (interrupt[i]) cur_id = ID_W'(i);
        end
    end

    // Later assignments take precedence: set_priority beats any rotation.
    always_comb begin
        isr_set  = '0;
        isr_clr  = '0;
        ptr_next = lowest_ptr;
        if (granted) begin
            if (!auto_eoi) isr_set = interrupt;
            else if (auto_rotate) ptr_next = cur_id;
        end
        if (eoi_nonspecific && isr_found) begin
            isr_clr[isr_id] = 1'b1;
            if (auto_rotate) ptr_next = isr_id;
        end
        if (eoi_specific && lvl_ok) isr_clr[eoi_level] = 1'b1;
        if (set_priority && lvl_ok) ptr_next = eoi_level;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr          <= '0;
            isr          <= '0;
            lowest_ptr   <= ID_W'(N_IRQ - 1);
            int_out      <= 1'b0;
            interrupt    <= '0;
            ack_id       <= '0;
            ack_spurious <= 1'b0;
        end else begin
            irr          <= interrupt_request & ~(granted ? interrupt : '0);
            isr          <= (isr & ~isr_clr) | isr_set;
            lowest_ptr   <= ptr_next;
            ack_spurious <= int_ack & ~int_out;
            if (int_ack) begin
                int_out   <= 1'b0;
                interrupt <= '0;
                ack_id    <= int_out ? cur_id : ID_W'(N_IRQ - 1);
            end else begin
                int_out   <= win;
                interrupt <= win_vec;
            end
        end
    end

endmodule
